fp_norm_round: RTL and testbench
================================

Name: fp_norm_round

Overview:
- Post-add normalise/round stage, directly downstream of the pipelined FP add/sub datapath.
- Consumes the raw adder result: sign, biased exponent, 24-bit mantissa, carry-out and guard/round/sticky bits.
- Produces a packed IEEE-754 single-precision word plus status flags through a 3-stage valid/ready pipeline.

Parameters:
- EXP_W, 8, biased exponent width.
- MAN_W, 23, stored fraction width; the internal mantissa is MAN_W+1 bits including the hidden bit.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  stage can accept a beat.
- in_sign  input  1  result sign from the adder.
- in_exp  input  EXP_W  biased exponent, aligned to the larger operand.
- in_mant  input  MAN_W+1  raw mantissa; bit MAN_W is the hidden-bit position.
- in_carry  input  1  adder carry-out, weight 2^(MAN_W+1).
- in_grs  input  3  guard, round, sticky bits from alignment.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- result  output  1+EXP_W+MAN_W  packed {sign, exp, frac}.
- flag_ovf, flag_unf, flag_zero, flag_inx  output  1 each  per-result flags, qualified by out_valid.

Behaviour:
- Value convention: {in_carry, in_mant} / 2^MAN_W * 2^(in_exp - bias).
- Global stall: advance = out_ready | ~out_valid, and in_ready = advance.
- When advance=0, every stage register holds.
- Bubbles are not collapsed. Order is preserved.
- Latency is exactly 3 cycles from an accepted beat to out_valid when never stalled. Throughput is 1 per cycle.
- S1, carry/zero detect:
  - in_carry=1: shift {carry, mant, grs} right by 1; the old sticky ORs into the new sticky; exp+1.
  - else {carry, mant}==0: mark as exact zero.
  - else: compute lzc = leading zeros of in_mant (0..MAN_W).
- S2, normalise:
  - zero-marked: result +0, flag_zero=1. Sign is forced to 0.
  - lzc>0 and exp <= lzc: flush to signed zero, flag_unf=1, flag_inx=1. No denormals are produced.
  - otherwise: shift {mant, g, r} left by lzc, filling with zeros; sticky is kept; exp -= lzc.
  - Internal exponent is EXP_W+2 bits signed, so no wrap-around.
- S3, round-to-nearest-even:
  - up = G & (R | S | L), where L = mant LSB.
  - mant+up carrying out of bit MAN_W: mant = 1000…0, exp+1.
  - flag_inx = G|R|S.
  - Final exp >= 2^EXP_W - 1: result = ±inf (exp all ones, frac 0), flag_ovf=1, flag_inx=1.
  - Otherwise result = {sign, exp[EXP_W-1:0], mant[MAN_W-1:0]}.
- Exponent 0xFF input (inf/NaN) is out of scope and is handled upstream.
- Reset:
  - All stage valids clear to 0; out_valid=0; result=0; all flags=0.
  - Reset mid-operation discards in-flight beats. in_ready=1 in the cycle after reset deasserts.

Optional Feature:
- Macro FP_NORM_STICKY_FLAGS_EN.
- When defined:
  - Adds input flag_clr (1) and output acc_flags (4: {ovf, unf, zero, inx}).
  - acc_flags ORs in the per-result flags of each transferred result (out_valid & out_ready).
  - flag_clr=1 clears acc_flags to 0. Same-cycle clear and set: set wins for that beat's flags.
  - Reset clears acc_flags.
- When undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package fp_pkg holds:
  - Constants EXP_W, MAN_W, BIAS=127 and EXP_MAX.
  - Typedefs for the packed result word and the per-stage record {valid, sign, exp, mant, grs, zero, unf}.
  - Enum of flag bit positions.
- One sub-module, fp_lzc: combinational leading-zero counter over MAN_W+1 bits, instantiated in S1.

Test Plan:
- Carry renormalise: carry=1, mant=0x800000, exp=0x80, grs=000 -> result 0x40C00000, all flags 0, out_valid 3 cycles later.
- Left normalise: carry=0, mant=0x000001, exp=0x7F -> 0x34000000.
- RNE ties:
  - mant=0x800001, grs=100, exp=0x7F -> 0x3F800002, inx=1.
  - mant=0x800000, grs=100 -> 0x3F800000, inx=1.
- Round carry: mant=0xFFFFFF, grs=110, exp=0x7F -> 0x40000000, inx=1.
- Overflow: sign=1, carry=1, mant=0x800000, exp=0xFE -> 0xFF800000, ovf=1, inx=1.
- Underflow and zero:
  - sign=1, mant=0x000100, exp=0x0A -> 0x80000000, unf=1.
  - mant=0, carry=0 -> 0x00000000, zero=1.
- Stall and reset:
  - 3 beats in flight, out_ready=0 for 5 cycles -> result held, in_ready=0, order kept on release.
  - rst pulse mid-stream -> out_valid=0 next cycle.
  - With FP_NORM_STICKY_FLAGS_EN: acc_flags accumulates and clears on flag_clr.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and record types for the FP normalise/round pipeline.
// Widths here size every stage register and the external bus.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = (1 << EXP_W) - 1;
    localparam int EXP_IW  = EXP_W + 2;
    localparam int LZC_W   = $clog2(MAN_W + 2);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp_word_t;

    typedef struct packed {
        logic              valid;
        logic              sign;
        logic [EXP_IW-1:0] exp;
        logic [MAN_W:0]    mant;
        logic [2:0]        grs;
        logic              zero;
        logic              unf;
    } stage_t;

    typedef enum logic [1:0] {
        FLAG_INX  = 2'd0,
        FLAG_ZERO = 2'd1,
        FLAG_UNF  = 2'd2,
        FLAG_OVF  = 2'd3
    } flag_pos_e;

endpackage

// File: rtl/fp_norm_round_if.sv
// Valid/ready bus between the adder, this stage and its consumer.
// slave is the normaliser's view, master the producer/consumer side.
interface fp_norm_round_if;
    import fp_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [MAN_W:0]   in_mant;
    logic             in_carry;
    logic [2:0]       in_grs;
    logic             out_valid;
    logic             out_ready;
    fp_word_t         result;
    logic             flag_ovf;
    logic             flag_unf;
    logic             flag_zero;
    logic             flag_inx;

    modport master (
        output in_valid, in_sign, in_exp, in_mant,
        output in_carry, in_grs, out_ready,
        input  in_ready, out_valid, result,
        input  flag_ovf, flag_unf, flag_zero, flag_inx
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant,
        input  in_carry, in_grs, out_ready,
        output in_ready, out_valid, result,
        output flag_ovf, flag_unf, flag_zero, flag_inx
    );

endinterface

// File: rtl/fp_lzc.sv
// Leading-zero counter over the MAN_W+1 bit mantissa.
// An all-zero input reports MAN_W+1.
module fp_lzc
    import fp_pkg::*;
(
    input  logic [MAN_W:0]   din,
    output logic [LZC_W-1:0] count
);

    always_comb begin
        count = LZC_W'(MAN_W + 1);
        for (int i = 0; i <= MAN_W; i++) begin
            if (din[i]) count = LZC_W'(MAN_W - i);
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// Post-add normalise and round-to-nearest-even, 3 pipeline stages.
// FP_NORM_STICKY_FLAGS_EN adds flag_clr and accumulated acc_flags.
module fp_norm_round
    import fp_pkg::*;
(
    input  logic clk,
    input  logic rst,
`ifdef FP_NORM_STICKY_FLAGS_EN
    input  logic       flag_clr,
    output logic [3:0] acc_flags,
`endif
    fp_norm_round_if.slave io
);

    logic             advance;
    stage_t           s1_d, s1_q, s2_d, s2_q;
    logic [LZC_W-1:0] lzc_cnt, lzc_d, lzc_q;
    logic [MAN_W+2:0] sh;

    logic              up, rnd_carry, ovf, inx;
    logic [MAN_W-1:0]  frac_r;
    logic [EXP_IW-1:0] exp_r;
    fp_word_t          word_d, word_q;
    logic [3:0]        flags_d, flags_q;
    logic              valid_q;

    assign advance     = io.out_ready | ~valid_q;
    assign io.in_ready = advance;

    fp_lzc u_lzc (
        .din   (io.in_mant),
        .count (lzc_cnt)
    );

    always_comb begin
        s1_d       = '0;
        s1_d.valid = io.in_valid;
        s1_d.sign  = io.in_sign;
        s1_d.exp   = {2'b00, io.in_exp};
        s1_d.mant  = io.in_mant;
        s1_d.grs   = io.in_grs;
        lzc_d      = '0;
        unique case (1'b1)
            io.in_carry: begin
                s1_d.exp  = {2'b00, io.in_exp} + EXP_IW'(1);
                s1_d.mant = {1'b1, io.in_mant[MAN_W:1]};
                s1_d.grs  = {io.in_mant[0], io.in_grs[2],
                             |io.in_grs[1:0]};
            end
            (~io.in_carry & ~|io.in_mant): s1_d.zero = 1'b1;
            default: lzc_d = lzc_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= '0;
            lzc_q <= '0;
        end else if (advance) begin
            s1_q  <= s1_d;
            lzc_q <= lzc_d;
        end
    end

    // Sticky stays in place; only guard and round move up into the mantissa.
    always_comb begin
        s2_d = s1_q;
        sh   = {s1_q.mant, s1_q.grs[2:1]} << lzc_q;
        unique case (1'b1)
            s1_q.zero: begin
                s2_d.sign = 1'b0;
                s2_d.exp  = '0;
                s2_d.mant = '0;
                s2_d.grs  = '0;
            end
            (~s1_q.zero & (lzc_q != '0) &
             ($signed(s1_q.exp) <= $signed(EXP_IW'(lzc_q)))): begin
                s2_d.unf  = 1'b1;
                s2_d.exp  = '0;
                s2_d.mant = '0;
                s2_d.grs  = '0;
            end
            default: begin
                s2_d.mant = sh[MAN_W+2:2];
                s2_d.grs  = {sh[1:0], s1_q.grs[0]};
                s2_d.exp  = s1_q.exp - EXP_IW'(lzc_q);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_q <= '0;
        end else if (advance) begin
            s2_q <= s2_d;
        end
    end

    // Hidden bit is set here, so an all-ones mantissa is the only round carry.
    always_comb begin
        up        = s2_q.grs[2] & (s2_q.grs[1] | s2_q.grs[0] | s2_q.mant[0]);
        rnd_carry = up & (&s2_q.mant);
        frac_r    = s2_q.mant[MAN_W-1:0] + MAN_W'(up);
        exp_r     = s2_q.exp + EXP_IW'(rnd_carry);
        ovf       = $signed(exp_r) >= $signed(EXP_IW'(EXP_MAX));
        inx       = |s2_q.grs;
        word_d    = '0;
        flags_d   = '0;
        unique case (1'b1)
            s2_q.zero: flags_d[FLAG_ZERO] = 1'b1;
            (~s2_q.zero & s2_q.unf): begin
                word_d.sign       = s2_q.sign;
                flags_d[FLAG_UNF] = 1'b1;
                flags_d[FLAG_INX] = 1'b1;
            end
            (~s2_q.zero & ~s2_q.unf & ovf): begin
                word_d.sign       = s2_q.sign;
                word_d.exp        = '1;
                flags_d[FLAG_OVF] = 1'b1;
                flags_d[FLAG_INX] = 1'b1;
            end
            default: begin
                word_d.sign       = s2_q.sign;
                word_d.exp        = exp_r[EXP_W-1:0];
                word_d.frac       = frac_r;
                flags_d[FLAG_INX] = inx;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            flags_q <= '0;
        end else if (advance) begin
            valid_q <= s2_q.valid;
            word_q  <= word_d;
            flags_q <= flags_d;
        end
    end

    assign io.out_valid = valid_q;
    assign io.result    = word_q;
    assign io.flag_ovf  = flags_q[FLAG_OVF];
    assign io.flag_unf  = flags_q[FLAG_UNF];
    assign io.flag_zero = flags_q[FLAG_ZERO];
    assign io.flag_inx  = flags_q[FLAG_INX];

`ifdef FP_NORM_STICKY_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_flags <= '0;
        end else if (valid_q & io.out_ready) begin
            acc_flags <= (flag_clr ? 4'b0 : acc_flags) | flags_q;
        end else if (flag_clr) begin
            acc_flags <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_fp_norm_round.sv
// Randomised bench for fp_norm_round with a value-level reference model.
// Scoreboard checks every transferred result; directed cases pin the model.
module tb_fp_norm_round;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_norm_round_if bus ();

`ifdef FP_NORM_STICKY_FLAGS_EN
    logic       flag_clr = 1'b0;
    logic [3:0] acc_flags;
    logic [3:0] acc_m = 4'b0;
`endif

    fp_norm_round dut (
        .clk       (clk),
        .rst       (rst),
`ifdef FP_NORM_STICKY_FLAGS_EN
        .flag_clr  (flag_clr),
        .acc_flags (acc_flags),
`endif
        .io        (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [35:0] sb_q[$];
    logic accepted = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns {ovf, unf, zero, inx, result}
    function automatic logic [35:0] model(input logic sign,
        input logic [7:0] exp, input logic [23:0] mant,
        input logic carry, input logic [2:0] grs);
        logic [26:0] b, n;
        int p, shamt, e;
        logic g, r, s, up;
        logic [24:0] m;
        logic [23:0] kept;
        if (!carry && mant == 24'd0) return {4'b0010, 32'h0};
        b = {carry, mant, grs[2:1]};
        p = -1;
        for (int i = 0; i < 27; i++) if (b[i]) p = i;
        shamt = 25 - p;
        e = int'(exp) - shamt;
        if (shamt > 0 && e <= 0) return {4'b0101, sign, 31'h0};
        if (shamt < 0) begin
            n = b >> 1;
            s = grs[0] | b[0];
        end else begin
            n = b << shamt;
            s = grs[0];
        end
        kept = n[25:2];
        g = n[1];
        r = n[0];
        up = g & (r | s | kept[0]);
        m = {1'b0, kept} + 25'(up);
        if (m == 25'h1000000) begin
            m = 25'h0800000;
            e = e + 1;
        end
        if (e >= 255) return {4'b1001, sign, 8'hFF, 23'h0};
        return {3'b000, g | r | s, sign, 8'(e), m[22:0]};
    endfunction

    function automatic logic [35:0] dut_word();
        return {bus.flag_ovf, bus.flag_unf, bus.flag_zero,
                bus.flag_inx, bus.result};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                accepted = 1'b0;
`ifdef FP_NORM_STICKY_FLAGS_EN
                acc_m = 4'b0;
`endif
            end else begin
`ifdef FP_NORM_STICKY_FLAGS_EN
                chk("acc_flags", 64'(acc_flags), 64'(acc_m));
                acc_m = (flag_clr ? 4'b0 : acc_m) |
                        ((bus.out_valid && bus.out_ready) ?
                         dut_word()[35:32] : 4'b0);
`endif
                if (bus.out_valid && bus.out_ready) begin
                    if (sb_q.size() == 0)
                        chk("unexpected_out", 64'd1, 64'd0);
                    else
                        chk("result", 64'(dut_word()), 64'(sb_q.pop_front()));
                end
                accepted = bus.in_valid && bus.in_ready;
                if (accepted)
                    sb_q.push_back(model(bus.in_sign, bus.in_exp,
                        bus.in_mant, bus.in_carry, bus.in_grs));
            end
        end
    end

    task automatic drive(input logic sign, input logic [7:0] exp,
        input logic [23:0] mant, input logic carry, input logic [2:0] grs);
        bus.in_valid = 1'b1;
        bus.in_sign  = sign;
        bus.in_exp   = exp;
        bus.in_mant  = mant;
        bus.in_carry = carry;
        bus.in_grs   = grs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sign, input logic [7:0] exp,
        input logic [23:0] mant, input logic carry, input logic [2:0] grs);
        int n;
        drive(sign, exp, mant, carry, grs);
        n = 0;
        tick();
        while (!accepted && n < 100) begin
            tick();
            n++;
        end
        if (!accepted) chk("send_timeout", 64'd1, 64'd0);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while ((sb_q.size() != 0 || bus.out_valid) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic rand_beat();
        logic [23:0] mant;
        logic [7:0] exp;
        mant = 24'($urandom) >> $urandom_range(0, 24);
        exp = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 30))
                                          : 8'($urandom_range(1, 254));
        drive(1'($urandom), exp, mant, ($urandom_range(0, 3) == 0),
              3'($urandom));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] held;
        int lat;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.in_carry  = 1'b0;
        bus.in_grs    = '0;
        bus.out_ready = 1'b1;

        chk("pin_carry", 64'(model(0, 8'h80, 24'h800000, 1, 3'b000)), 64'h0_40C00000);
        chk("pin_lnorm", 64'(model(0, 8'h7F, 24'h000001, 0, 3'b000)), 64'h0_34000000);
        chk("pin_tie_up", 64'(model(0, 8'h7F, 24'h800001, 0, 3'b100)), 64'h1_3F800002);
        chk("pin_tie_even", 64'(model(0, 8'h7F, 24'h800000, 0, 3'b100)), 64'h1_3F800000);
        chk("pin_rnd_carry", 64'(model(0, 8'h7F, 24'hFFFFFF, 0, 3'b110)), 64'h1_40000000);
        chk("pin_ovf", 64'(model(1, 8'hFE, 24'h800000, 1, 3'b000)), 64'h9_FF800000);
        chk("pin_unf", 64'(model(1, 8'h0A, 24'h000100, 0, 3'b000)), 64'h5_80000000);
        chk("pin_zero", 64'(model(1, 8'h40, 24'h000000, 0, 3'b011)), 64'h2_00000000);

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_result", 64'(dut_word()), 64'd0);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        tick();

        drive(0, 8'h80, 24'h800000, 1, 3'b000);
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", 64'(lat), 64'd3);
        chk("lat_result", 64'(dut_word()), 64'h0_40C00000);
        tick();

        send(0, 8'h7F, 24'h000001, 0, 3'b000);
        send(0, 8'h7F, 24'h800001, 0, 3'b100);
        send(0, 8'h7F, 24'h800000, 0, 3'b100);
        send(0, 8'h7F, 24'hFFFFFF, 0, 3'b110);
        send(1, 8'hFE, 24'h800000, 1, 3'b000);
        send(1, 8'h0A, 24'h000100, 0, 3'b000);
        send(1, 8'h33, 24'h000000, 0, 3'b000);
        drain();

        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_beat();
            tick();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        held = dut_word();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", 64'(dut_word()), 64'(held));
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        tick();
        bus.out_ready = 1'b1;
        drain();

        send(0, 8'h7F, 24'h000001, 0, 3'b000);
        send(0, 8'h7F, 24'h800001, 0, 3'b100);
        drive(1, 8'h7F, 24'h000100, 0, 3'b000);
        tick();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", 64'(dut_word()), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_discard", 64'(bus.out_valid), 64'd0);
        end
        tick();

        for (int c = 0; c < 4000; c++) begin
            if (!bus.in_valid || accepted) begin
                if ($urandom_range(0, 3) != 0) rand_beat();
                else bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef FP_NORM_STICKY_FLAGS_EN
            flag_clr = ($urandom_range(0, 15) == 0);
`endif
            tick();
        end
`ifdef FP_NORM_STICKY_FLAGS_EN
        flag_clr = 1'b0;
`endif
        drain();

`ifdef FP_NORM_STICKY_FLAGS_EN
        send(1, 8'hFE, 24'h800000, 1, 3'b000);
        drain();
        @(negedge clk);
        chk("acc_set", 64'(acc_flags), 64'h9);
        tick();
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        @(negedge clk);
        chk("acc_clr", 64'(acc_flags), 64'h0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
